// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS fetch front end: FSM encoding, reset vector,
// redirect kinds and the control-transfer opcodes decoded in D.
package cpu_pkg;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_J    = 2'd2,
    REDIR_JR   = 2'd3
  } redir_kind_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;

endpackage

// File: rtl/npc_target.sv
// Combinational redirect-target generator for the D-stage control transfer;
// jr outranks j, which outranks a taken conditional branch.
module npc_target
  import cpu_pkg::*;
(
  input  logic        d_branch,
  input  logic        cmp_jump,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic        d_j,
  input  logic [25:0] d_index,
  input  logic        d_jr,
  input  logic [31:0] d_rs_val,
  output redir_kind_e kind,
  output logic [31:0] target
);

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;

  // Branch and jump targets are relative to the delay-slot address.
  assign pc4    = d_pc + 32'd4;
  assign br_tgt = pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign j_tgt  = {pc4[31:28], d_index, 2'b00};
  assign jr_tgt = d_rs_val & 32'hFFFF_FFFC;

  always_comb begin
    kind   = REDIR_NONE;
    target = br_tgt;
    if (d_jr) begin
      kind   = REDIR_JR;
      target = jr_tgt;
    end else if (d_j) begin
      kind   = REDIR_J;
      target = j_tgt;
    end else if (d_branch && cmp_jump) begin
      kind   = REDIR_BR;
      target = br_tgt;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// IF-stage sequencer: owns the PC, runs the imem handshake, parks a returned
// word during a stall, and applies D-stage redirects after the delay slot.
module fetch_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        d_branch,
  input  logic        cmp_jump,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic        d_j,
  input  logic [25:0] d_index,
  input  logic        d_jr,
  input  logic [31:0] d_rs_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        f_fire,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_v_q, pend_v_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic [31:0]  held_q, held_d;

  redir_kind_e  redir_kind;
  logic [31:0]  target_now;
  logic         redir_now;

  npc_target u_npc_target (
    .d_branch (d_branch),
    .cmp_jump (cmp_jump),
    .d_pc     (d_pc),
    .d_imm16  (d_imm16),
    .d_j      (d_j),
    .d_index  (d_index),
    .d_jr     (d_jr),
    .d_rs_val (d_rs_val),
    .kind     (redir_kind),
    .target   (target_now)
  );

  assign redir_now = ~stall & (redir_kind != REDIR_NONE);
  assign imem_addr = pc_q;
  assign f_pc      = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    held_d     = held_q;
    imem_req   = 1'b0;
    f_fire     = 1'b0;
    f_instr    = imem_rdata;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !stall) begin
          f_fire = ~reset;
        end else if (imem_ready && stall) begin
          held_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        f_instr = held_q;
        if (!stall) begin
          f_fire  = ~reset;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // The instruction leaving F is the delay slot whenever a redirect is live.
    if (f_fire) begin
      pend_v_d = 1'b0;
      if (redir_now)     pc_d = target_now;
      else if (pend_v_q) pc_d = pend_tgt_q;
      else               pc_d = pc_q + 32'd4;
    end else if (redir_now) begin
      pend_v_d   = 1'b1;
      pend_tgt_d = target_now;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
      held_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      held_q     <= held_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vectors with literal expectations
// plus a per-cycle comparison against an instruction-stream model.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, d_branch, cmp_jump, d_j, d_jr;
  logic [31:0] d_pc, d_rs_val;
  logic [15:0] d_imm16;
  logic [25:0] d_index;
  logic        imem_req, imem_ready, f_fire;
  logic [31:0] imem_addr, imem_rdata, f_pc, f_instr;
  logic        use_fixed;
  logic [31:0] fixed_word;

  int checks = 0;
  int errors = 0;

  // Model: address of the next instruction to deliver, a parked word, and a
  // deferred redirect target.
  bit          m_valid = 1'b0;
  logic [31:0] m_next;
  bit          m_have;
  logic [31:0] m_word;
  bit          m_pend;
  logic [31:0] m_ptgt;

  always #5 clk = ~clk;

  always_comb imem_rdata = use_fixed ? fixed_word : (imem_addr ^ 32'h5A5A_0000);

  fetch_redirect_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .d_branch   (d_branch),
    .cmp_jump   (cmp_jump),
    .d_pc       (d_pc),
    .d_imm16    (d_imm16),
    .d_j        (d_j),
    .d_index    (d_index),
    .d_jr       (d_jr),
    .d_rs_val   (d_rs_val),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .f_fire     (f_fire),
    .f_pc       (f_pc),
    .f_instr    (f_instr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] spec_target(output bit taken);
    taken = 1'b1;
    if (d_jr)                  return {d_rs_val[31:2], 2'b00};
    if (d_j)                   return ((d_pc + 32'd4) & 32'hF000_0000) | ({6'd0, d_index} * 32'd4);
    if (d_branch && cmp_jump)  return d_pc + 32'd4 + 32'($signed(d_imm16)) * 32'd4;
    taken = 1'b0;
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    bit          taken, exp_fire, redir;
    logic [31:0] tgt;
    if (reset) begin
      chk("fire_in_reset", {31'd0, f_fire}, 32'd0);
      m_valid = 1'b1;
      m_next  = 32'h0000_3000;
      m_have  = 1'b0;
      m_pend  = 1'b0;
    end else if (m_valid) begin
      exp_fire = !stall && (m_have || imem_ready);
      chk("m_req", {31'd0, imem_req}, {31'd0, !m_have});
      chk("m_addr", imem_addr, m_next);
      chk("m_fire", {31'd0, f_fire}, {31'd0, exp_fire});
      if (exp_fire) begin
        chk("m_fpc", f_pc, m_next);
        chk("m_finstr", f_instr, m_have ? m_word : imem_rdata);
      end
      tgt   = spec_target(taken);
      redir = taken && !stall;
      if (exp_fire) begin
        m_next = redir ? tgt : (m_pend ? m_ptgt : m_next + 32'd4);
        m_pend = 1'b0;
        m_have = 1'b0;
      end else begin
        if (!m_have && imem_ready && stall) begin
          m_have = 1'b1;
          m_word = imem_rdata;
        end
        if (redir) begin
          m_pend = 1'b1;
          m_ptgt = tgt;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    d_branch = 0; cmp_jump = 0; d_j = 0; d_jr = 0;
    d_pc = 0; d_imm16 = 0; d_index = 0; d_rs_val = 0;
  endtask

  task automatic do_reset();
    reset = 1; imem_ready = 0; stall = 0; clear_d();
    cyc();
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    use_fixed = 0; fixed_word = 0;
    do_reset();
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_fire", {31'd0, f_fire}, 32'd0);

    // Back-to-back fetch
    imem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("seq_fire", {31'd0, f_fire}, 32'd1);
      chk("seq_fpc", f_pc, 32'h3000 + 32'(i) * 4);
      cyc();
    end

    // Taken branch alongside the delay-slot fire
    do_reset(); imem_ready = 1; cyc();
    d_branch = 1; cmp_jump = 1; d_pc = 32'h3000; d_imm16 = 16'h0003;
    #1; chk("br_ds_fpc", f_pc, 32'h3004);
    cyc(); clear_d(); #1;
    chk("br_addr", imem_addr, 32'h3010);

    // Same branch while the delay slot is still outstanding
    do_reset(); imem_ready = 1; cyc();
    imem_ready = 0; d_branch = 1; cmp_jump = 1; d_pc = 32'h3000; d_imm16 = 16'h0003;
    cyc(); clear_d(); cyc(); cyc(); #1;
    chk("pend_wait_addr", imem_addr, 32'h3004);
    imem_ready = 1; #1;
    chk("pend_ds_fire", {31'd0, f_fire}, 32'd1);
    chk("pend_ds_fpc", f_pc, 32'h3004);
    cyc(); #1;
    chk("pend_addr", imem_addr, 32'h3010);
    cyc(); #1;
    chk("pend_cleared", imem_addr, 32'h3014);

    // Returned word parked during a stall
    use_fixed = 1; fixed_word = 32'h1234_5678; stall = 1;
    cyc(); use_fixed = 0; #1;
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;
    chk("hold_req2", {31'd0, imem_req}, 32'd0);
    chk("hold_fire", {31'd0, f_fire}, 32'd0);
    stall = 0; #1;
    chk("hold_rel_fire", {31'd0, f_fire}, 32'd1);
    chk("hold_rel_instr", f_instr, 32'h1234_5678);
    chk("hold_rel_fpc", f_pc, 32'h3014);
    cyc(); #1;
    chk("hold_next", imem_addr, 32'h3018);

    // jr outranks j
    d_jr = 1; d_j = 1; d_index = 26'h0000_100; d_rs_val = 32'h0000_4003;
    cyc(); clear_d(); #1;
    chk("jr_prio", imem_addr, 32'h0000_4000);

    // j alone, not-taken branch, negative offset
    d_j = 1; d_pc = 32'h0000_4000; d_index = 26'h0000_100;
    cyc(); clear_d(); #1;
    chk("j_addr", imem_addr, 32'h0000_0400);
    d_branch = 1; cmp_jump = 0; d_pc = 32'h0000_4000; d_imm16 = 16'h0010;
    cyc(); clear_d(); #1;
    chk("nt_addr", imem_addr, 32'h0000_0404);
    d_branch = 1; cmp_jump = 1; d_pc = 32'h0000_0500; d_imm16 = 16'hFFFE;
    cyc(); clear_d(); #1;
    chk("neg_br_addr", imem_addr, 32'h0000_04FC);

    // Wrap at the top of the address space, then reset out of S_HOLD
    d_jr = 1; d_rs_val = 32'hFFFF_FFFF;
    cyc(); clear_d(); #1;
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    stall = 1; cyc(); #1;
    chk("wrap_hold_req", {31'd0, imem_req}, 32'd0);
    stall = 0; reset = 1; #1;
    chk("rst_hold_fire", {31'd0, f_fire}, 32'd0);
    cyc(); reset = 0; imem_ready = 0; #1;
    chk("rst_hold_addr", imem_addr, 32'h0000_3000);
    chk("rst_hold_fire2", {31'd0, f_fire}, 32'd0);

    // Mixed ready/stall pattern with occasional jumps, checked by the model
    for (int i = 0; i < 40; i++) begin
      imem_ready = (i % 3) != 1;
      stall      = (i % 5) == 2;
      d_j        = ((i % 7) == 3) && !m_pend;
      d_pc       = 32'(i) * 16;
      d_index    = 26'h100 + 26'(i);
      cyc();
    end
    clear_d(); imem_ready = 0; stall = 0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
